// File: rtl/conv_pkg.sv
// Window geometry shared by the window generator and the convolution stage.
// Combinational helpers only, no storage.
package conv_pkg;

  localparam int KERNEL_DIM  = 3;
  localparam int KERNEL_SIZE = KERNEL_DIM * KERNEL_DIM;
  localparam int DATA_WIDTH  = 32;

  // Word slot of window position (i,j), both 1-based; (1,1) is the lowest word.
  function automatic int win_idx(input int i, input int j);
    return (i - 1) * KERNEL_DIM + (j - 1);
  endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel stream in, 3x3 window out; no ready signal, the consumer always accepts.
// master = pixel source / window sink, slave = window generator.
interface conv_window_gen_if #(
  parameter int DataWidth = conv_pkg::DATA_WIDTH
);
  import conv_pkg::*;

  logic [DataWidth-1:0]             pixel_in;
  logic                             pixel_valid;
  logic [KERNEL_SIZE*DataWidth-1:0] window_out;
  logic                             window_valid;
  logic                             frame_done;

  modport master (
    output pixel_in, pixel_valid,
    input  window_out, window_valid, frame_done
  );

  modport slave (
    input  pixel_in, pixel_valid,
    output window_out, window_valid, frame_done
  );

endinterface

// File: rtl/conv_line_buffer.sv
// Shift-enable delay line: data_out is the word accepted Depth enables ago.
// No reset on storage; contents are only meaningful once filled.
module conv_line_buffer #(
  parameter int DataWidth = 32,
  parameter int Depth     = 28
) (
  input  logic                 Clk,
  input  logic [DataWidth-1:0] data_in,
  input  logic                 shift_en,
  output logic [DataWidth-1:0] data_out
);

  logic [DataWidth-1:0] mem [Depth];

  always_ff @(posedge Clk) begin
    if (shift_en) begin
      mem[0] <= data_in;
      for (int i = 1; i < Depth; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign data_out = mem[Depth-1];

endmodule

// File: rtl/conv_window_gen.sv
// 3x3 sliding-window generator over a raster pixel stream; window/frame_done one cycle after accept.
// No backpressure. Define CONV_WINDOW_STRIDE2_EN for stride-2 window selection.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int DataWidth = DATA_WIDTH,
  parameter int ImgWidth  = 28,
  parameter int ImgHeight = 28
) (
  input  logic              Clk,
  input  logic              Rst,
  conv_window_gen_if.slave  win_if
);

  localparam int ColW = $clog2(ImgWidth);
  localparam int RowW = $clog2(ImgHeight);

  logic [ColW-1:0]      col;
  logic [RowW-1:0]      row;
  logic                 accept;
  logic                 last_col;
  logic                 last_row;
  logic                 win_ok;
  logic                 window_valid_q;
  logic                 frame_done_q;
  logic [DataWidth-1:0] tap [KERNEL_DIM];
  logic [DataWidth-1:0] win [KERNEL_DIM][KERNEL_DIM];

  assign accept   = win_if.pixel_valid && !Rst;
  assign last_col = (col == ColW'(ImgWidth - 1));
  assign last_row = (row == RowW'(ImgHeight - 1));

`ifdef CONV_WINDOW_STRIDE2_EN
  // Row/col offsets from 2 are even exactly when row/col themselves are even.
  assign win_ok = (row >= RowW'(2)) && (col >= ColW'(2)) && !row[0] && !col[0];
`else
  assign win_ok = (row >= RowW'(2)) && (col >= ColW'(2));
`endif

  // Window row 0 (oldest) is fed from two rows back, row 2 from the live pixel.
  assign tap[2] = win_if.pixel_in;

  conv_line_buffer #(.DataWidth(DataWidth), .Depth(ImgWidth)) u_line0 (
    .Clk      (Clk),
    .data_in  (win_if.pixel_in),
    .shift_en (accept),
    .data_out (tap[1])
  );

  conv_line_buffer #(.DataWidth(DataWidth), .Depth(ImgWidth)) u_line1 (
    .Clk      (Clk),
    .data_in  (tap[1]),
    .shift_en (accept),
    .data_out (tap[0])
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      row            <= '0;
      col            <= '0;
      window_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
      for (int i = 0; i < KERNEL_DIM; i++) begin
        for (int j = 0; j < KERNEL_DIM; j++) begin
          win[i][j] <= '0;
        end
      end
    end else begin
      window_valid_q <= accept && win_ok;
      frame_done_q   <= accept && last_col && last_row;
      if (accept) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        for (int i = 0; i < KERNEL_DIM; i++) begin
          for (int j = 0; j < KERNEL_DIM - 1; j++) begin
            win[i][j] <= win[i][j+1];
          end
          win[i][KERNEL_DIM-1] <= tap[i];
        end
      end
    end
  end

  for (genvar gi = 0; gi < KERNEL_DIM; gi++) begin : g_row
    for (genvar gj = 0; gj < KERNEL_DIM; gj++) begin : g_col
      assign win_if.window_out[win_idx(gi + 1, gj + 1)*DataWidth +: DataWidth] = win[gi][gj];
    end
  end

  assign win_if.window_valid = window_valid_q;
  assign win_if.frame_done   = frame_done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Drives a 4x4 and a 28x28 window generator and checks every cycle against a
// model that rebuilds each window directly from the stored frame.
module tb_conv_window_gen;
  import conv_pkg::*;

  localparam int DW = 32;
  localparam int WW = KERNEL_SIZE * DW;
  localparam int NI = 2;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  conv_window_gen_if #(.DataWidth(DW)) if_s ();
  conv_window_gen_if #(.DataWidth(DW)) if_l ();

  conv_window_gen #(.DataWidth(DW), .ImgWidth(4), .ImgHeight(4)) dut_s (
    .Clk    (Clk),
    .Rst    (Rst),
    .win_if (if_s.slave)
  );

  conv_window_gen #(.DataWidth(DW), .ImgWidth(28), .ImgHeight(28)) dut_l (
    .Clk    (Clk),
    .Rst    (Rst),
    .win_if (if_l.slave)
  );

  logic          pv   [NI];
  logic [DW-1:0] pin  [NI];
  logic          ovld [NI];
  logic          ofd  [NI];
  logic [WW-1:0] oout [NI];

  assign if_s.pixel_valid = pv[0];
  assign if_s.pixel_in    = pin[0];
  assign if_l.pixel_valid = pv[1];
  assign if_l.pixel_in    = pin[1];
  assign ovld[0] = if_s.window_valid;
  assign ofd[0]  = if_s.frame_done;
  assign oout[0] = if_s.window_out;
  assign ovld[1] = if_l.window_valid;
  assign ofd[1]  = if_l.frame_done;
  assign oout[1] = if_l.window_out;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic int img_w(input int n);
    return (n == 0) ? 4 : 28;
  endfunction

  function automatic int exp_wins(input int w, input int h);
`ifdef CONV_WINDOW_STRIDE2_EN
    return ((w - 1) / 2) * ((h - 1) / 2);
`else
    return (w - 2) * (h - 2);
`endif
  endfunction

  // Reference model: pixel index k within the frame gives (r,c) directly.
  int            k     [NI];
  logic          ev    [NI];
  logic          ef    [NI];
  logic          known [NI];
  logic [WW-1:0] eo    [NI];
  logic [DW-1:0] img   [NI][784];
  bit            armed = 1'b0;

  always @(posedge Clk) begin
    for (int n = 0; n < NI; n++) begin
      int  w, r, c;
      bit  ok;
      w = img_w(n);
      if (Rst) begin
        k[n] = 0; ev[n] = 1'b0; ef[n] = 1'b0; eo[n] = '0; known[n] = 1'b1;
        armed = 1'b1;
      end else if (pv[n]) begin
        img[n][k[n]] = pin[n];
        r = k[n] / w;
        c = k[n] % w;
        ok = (r >= 2) && (c >= 2);
`ifdef CONV_WINDOW_STRIDE2_EN
        ok = ok && ((r - 2) % 2 == 0) && ((c - 2) % 2 == 0);
`endif
        ev[n] = ok;
        ef[n] = (k[n] == w * w - 1);
        known[n] = ok;
        if (ok) begin
          for (int i = 1; i <= 3; i++)
            for (int j = 1; j <= 3; j++)
              eo[n][((i-1)*3 + (j-1))*DW +: DW] = img[n][(r-3+i)*w + (c-3+j)];
        end
        k[n] = (k[n] + 1) % (w * w);
      end else begin
        ev[n] = 1'b0;
        ef[n] = 1'b0;
      end
    end
  end

  int wcnt [NI] = '{0, 0};
  int fcnt [NI] = '{0, 0};

  always @(negedge Clk) begin
    if (armed) begin
      for (int n = 0; n < NI; n++) begin
        chk($sformatf("window_valid[%0d]", n), WW'(ovld[n]), WW'(ev[n]));
        chk($sformatf("frame_done[%0d]", n), WW'(ofd[n]), WW'(ef[n]));
        if (known[n]) chk($sformatf("window_out[%0d]", n), oout[n], eo[n]);
        wcnt[n] += int'(ovld[n]);
        fcnt[n] += int'(ofd[n]);
      end
    end
  end

  task automatic feed(input int n, input int base, input int cnt, input bit gaps);
    for (int i = 0; i < cnt; i++) begin
      pv[n] = 1'b1; pin[n] = DW'(base + i);
      @(negedge Clk);
      if (gaps) begin
        pv[n] = 1'b0; pin[n] = $urandom;
        @(negedge Clk);
      end
    end
    pv[n] = 1'b0;
  endtask

  task automatic idle(input int cyc);
    repeat (cyc) @(negedge Clk);
  endtask

  task automatic phase_counts(input string tag, input int n, input int w0, input int f0,
                              input int frames);
    chk({tag, "_windows"}, WW'(wcnt[n] - w0), WW'(frames * exp_wins(img_w(n), img_w(n))));
    chk({tag, "_frames"}, WW'(fcnt[n] - f0), WW'(frames));
  endtask

  initial begin
    int w0, f0;
    pv[0] = 1'b0; pv[1] = 1'b0; pin[0] = '0; pin[1] = '0;
    Rst = 1'b1;
    idle(3);
    chk("rst_window_out", oout[0], '0);
    chk("rst_window_valid", WW'(ovld[0]), '0);
    chk("rst_frame_done", WW'(ofd[1]), '0);
    Rst = 1'b0;
    idle(2);

    w0 = wcnt[0]; f0 = fcnt[0];
    feed(0, 1, 16, 1'b0); idle(3);
    phase_counts("cont4x4", 0, w0, f0, 1);

    w0 = wcnt[0]; f0 = fcnt[0];
    feed(0, 1, 16, 1'b1); idle(3);
    phase_counts("gap4x4", 0, w0, f0, 1);

    w0 = wcnt[0]; f0 = fcnt[0];
    feed(0, 1, 16, 1'b0);
    feed(0, 101, 16, 1'b0); idle(3);
    phase_counts("b2b4x4", 0, w0, f0, 2);

    feed(0, 1, 7, 1'b0);
    Rst = 1'b1; pv[0] = 1'b1; pin[0] = 32'hdead_beef;
    idle(2);
    Rst = 1'b0; pv[0] = 1'b0;
    w0 = wcnt[0]; f0 = fcnt[0];
    idle(2);
    feed(0, 1, 16, 1'b0); idle(3);
    phase_counts("rst4x4", 0, w0, f0, 1);

    w0 = wcnt[1]; f0 = fcnt[1];
    for (int i = 0; i < 28 * 28; i++) begin
      pv[1] = 1'b1; pin[1] = $urandom;
      @(negedge Clk);
      if ($urandom_range(0, 3) == 0) begin
        pv[1] = 1'b0; pin[1] = $urandom;
        @(negedge Clk);
      end
    end
    pv[1] = 1'b0;
    idle(3);
    phase_counts("rand28x28", 1, w0, f0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
